// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction field positions,
// architectural register numbers and the FSM state type.
package decode_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 27;
    localparam int unsigned RD_MSB  = 26;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS_MSB  = 21;
    localparam int unsigned RS_LSB  = 17;
    localparam int unsigned RT_MSB  = 16;
    localparam int unsigned RT_LSB  = 12;
    localparam int unsigned IMM_MSB = 16;

    localparam logic [4:0] REG_RA      = 5'd31;
    localparam logic [4:0] REG_RSTATUS = 5'd30;

    typedef enum logic {RUN, REPLAY} state_e;

endpackage

// File: rtl/decode_hazard.sv
// Combinational operand-address decode and hazard detection for the decode stage:
// load-use against the lw in EX, and jr source against any EX register write.
module decode_hazard
    import decode_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned RW = 5
) (
    input  logic [W-1:0]  cur_ins,
    input  logic [W-1:0]  ex_ins,
    input  logic          ex_valid,
    output logic [RW-1:0] addr_a,
    output logic [RW-1:0] addr_b,
    output logic          use_a,
    output logic          use_b,
    output logic          load_use,
    output logic          jr_src
);

    logic [4:0]    op, ex_op;
    logic [RW-1:0] rd, rs, rt, ex_rd, ex_dest;
    logic          ex_writes;

    assign op    = cur_ins[OP_MSB:OP_LSB];
    assign rd    = cur_ins[RD_MSB:RD_LSB];
    assign rs    = cur_ins[RS_MSB:RS_LSB];
    assign rt    = cur_ins[RT_MSB:RT_LSB];
    assign ex_op = ex_ins[OP_MSB:OP_LSB];
    assign ex_rd = ex_ins[RD_MSB:RD_LSB];

    always_comb begin
        addr_a = '0;
        addr_b = '0;
        case (op)
            OP_RTYPE:       begin addr_a = rs; addr_b = rt; end
            OP_ADDI, OP_LW: addr_a = rs;
            OP_SW:          begin addr_a = rs; addr_b = rd; end
            OP_BNE, OP_BLT: begin addr_a = rd; addr_b = rs; end
            OP_JR:          addr_a = rd;
            OP_BEX:         addr_a = RW'(REG_RSTATUS);
            default:        ;
        endcase
    end

    // Unused operands decode to $0, so a nonzero address means a real source.
    assign use_a = (addr_a != '0);
    assign use_b = (addr_b != '0);

    assign ex_writes = ex_valid && (ex_op == OP_RTYPE || ex_op == OP_ADDI || ex_op == OP_LW ||
                                    ex_op == OP_SETX  || ex_op == OP_JAL);

    always_comb begin
        ex_dest = ex_rd;
        if (ex_op == OP_JAL)       ex_dest = RW'(REG_RA);
        else if (ex_op == OP_SETX) ex_dest = RW'(REG_RSTATUS);
    end

    assign load_use = ex_valid && (ex_op == OP_LW) && (ex_rd != '0) &&
                      ((use_a && addr_a == ex_rd) || (use_b && addr_b == ex_rd));

    assign jr_src = (op == OP_JR) && ex_writes && (ex_dest != '0) && (ex_dest == rd);

    logic unused_bits;
    assign unused_bits = ^{cur_ins[RT_LSB-1:0], ex_ins[RD_LSB-1:0]};

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: regfile read, jal/jr redirect, hazard stall with replay buffer,
// ID/EX register. Optional stall/flush counters when DECODE_PERF_EN is defined.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clock,
    input  logic          aclr,
    input  logic [W-1:0]  ins_in,
    input  logic [W-1:0]  pc_in,
    input  logic [W-1:0]  j_in,
    input  logic          br_flush,
    output logic [RW-1:0] rf_addr_a,
    output logic [RW-1:0] rf_addr_b,
    input  logic [W-1:0]  rf_data_a,
    input  logic [W-1:0]  rf_data_b,
    output logic          stall_a,
    output logic          jal_jr,
    output logic [W-1:0]  jal_jr_val,
    output logic          jal_jr_clr,
    output logic [W-1:0]  ex_ins,
    output logic [W-1:0]  ex_pc,
    output logic [W-1:0]  ex_a,
    output logic [W-1:0]  ex_b,
    output logic [W-1:0]  ex_imm,
    output logic [W-1:0]  ex_target,
    output logic          ex_valid
`ifdef DECODE_PERF_EN
    ,
    output logic [W-1:0]  stall_count,
    output logic [W-1:0]  flush_count
`endif
);

    state_e        state_q;
    logic [W-1:0]  buf_ins_q, buf_pc_q, buf_tgt_q;
    logic [W-1:0]  cur_ins, cur_pc, cur_tgt, imm_ext;
    logic [4:0]    cur_op;
    logic          use_a, use_b, load_use, jr_src, hazard;

    // While replaying, fetch is outputting a bubble; the buffer is the real instruction.
    assign cur_ins = (state_q == REPLAY) ? buf_ins_q : ins_in;
    assign cur_pc  = (state_q == REPLAY) ? buf_pc_q  : pc_in;
    assign cur_tgt = (state_q == REPLAY) ? buf_tgt_q : j_in;
    assign cur_op  = cur_ins[OP_MSB:OP_LSB];
    assign imm_ext = {{(W-IMM_MSB-1){cur_ins[IMM_MSB]}}, cur_ins[IMM_MSB:0]};

    decode_hazard #(
        .W  (W),
        .RW (RW)
    ) u_hazard (
        .cur_ins  (cur_ins),
        .ex_ins   (ex_ins),
        .ex_valid (ex_valid),
        .addr_a   (rf_addr_a),
        .addr_b   (rf_addr_b),
        .use_a    (use_a),
        .use_b    (use_b),
        .load_use (load_use),
        .jr_src   (jr_src)
    );

    // Replay never re-stalls: the producer has moved past EX by then.
    assign hazard  = (state_q == RUN) && !br_flush && (load_use || jr_src);
    assign stall_a = hazard;

    always_comb begin
        jal_jr     = 1'b0;
        jal_jr_val = '0;
        if (!br_flush && !hazard) begin
            if (cur_op == OP_JAL) begin
                jal_jr     = 1'b1;
                jal_jr_val = cur_tgt;
            end else if (cur_op == OP_JR) begin
                jal_jr     = 1'b1;
                jal_jr_val = rf_data_a;
            end
        end
    end

    assign jal_jr_clr = jal_jr;

    always_ff @(posedge clock) begin
        if (aclr) begin
            state_q   <= RUN;
            buf_ins_q <= '0;
            buf_pc_q  <= '0;
            buf_tgt_q <= '0;
            ex_ins    <= '0;
            ex_pc     <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
            ex_target <= '0;
            ex_valid  <= 1'b0;
        end else begin
            if (br_flush || hazard || cur_ins == '0) begin
                ex_ins    <= '0;
                ex_pc     <= '0;
                ex_a      <= '0;
                ex_b      <= '0;
                ex_imm    <= '0;
                ex_target <= '0;
                ex_valid  <= 1'b0;
            end else begin
                ex_ins    <= cur_ins;
                ex_pc     <= cur_pc;
                ex_a      <= rf_data_a;
                ex_b      <= rf_data_b;
                ex_imm    <= imm_ext;
                ex_target <= cur_tgt;
                ex_valid  <= 1'b1;
            end
            if (br_flush) begin
                state_q   <= RUN;
                buf_ins_q <= '0;
                buf_pc_q  <= '0;
                buf_tgt_q <= '0;
            end else if (hazard) begin
                state_q   <= REPLAY;
                buf_ins_q <= cur_ins;
                buf_pc_q  <= cur_pc;
                buf_tgt_q <= cur_tgt;
            end else begin
                state_q   <= RUN;
            end
        end
    end

`ifdef DECODE_PERF_EN
    always_ff @(posedge clock) begin
        if (aclr) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_a) stall_count <= stall_count + 1'b1;
            if (br_flush && cur_ins != '0) flush_count <= flush_count + 1'b1;
        end
    end
`endif

    logic unused_flags;
    assign unused_flags = use_a ^ use_b;

endmodule
